// File: rtl/display_scroller_if.sv
// -----------------------------------------------------------------------------
// display_scroller_if
//   Message-load channel between the application logic (producer) and
//   display_scroller (consumer).
//
//   Signals:
//     load_valid : producer has a code on load_code this cycle
//     load_ready : consumer accepts a code this cycle
//     load_code  : 4-bit display code to append to the message
//     load_last  : marks load_code as the final code of the message
//
//   Handshake: a code transfers on a rising clock edge where load_valid and
//   load_ready are both high. load_code and load_last are only meaningful
//   while load_valid is high. The producer holds load_valid, load_code and
//   load_last stable until the transfer happens. load_ready may be high
//   without load_valid and never depends combinationally on load_valid.
//
//   Modports:
//     master : the producer (drives valid/code/last, observes ready)
//     slave  : display_scroller (observes valid/code/last, drives ready)
// -----------------------------------------------------------------------------
interface display_scroller_if;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_code;
    logic       load_last;

    modport master (
        output load_valid,
        output load_code,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_code,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/display_scroller.sv
// -----------------------------------------------------------------------------
// display_scroller
//   Holds a short message of 4-bit display codes and scrolls it right-to-left
//   across a four-digit seven-segment multiplexer at a programmable step rate,
//   once or continuously.
//
//   Ports:
//     clock      : system clock, rising edge
//     reset      : asynchronous active-low reset
//     clear      : synchronous flush, empties the buffer and returns to IDLE
//     ld         : message-load channel (valid/ready, see display_scroller_if)
//     start      : begin scrolling (honoured in READY only)
//     pause      : freeze step prescaler and scroll position while high
//     loop_en    : 1 = restart after the last step, 0 = one-shot
//     fourth     : leftmost digit code
//     third      : digit code
//     second     : digit code
//     first      : rightmost digit code
//     busy       : high while scrolling
//     done       : one-cycle pulse when a one-shot scroll completes
//     dbg_state  : current FSM state (IDLE=0, READY=1, SCROLL=2)
// -----------------------------------------------------------------------------
module display_scroller #(
    parameter int         MSG_LEN  = 8,
    parameter int         TICK_DIV = 25000000,
    parameter logic [3:0] PAD      = 4'd15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    display_scroller_if.slave  ld,
    input  logic               start,
    input  logic               pause,
    input  logic               loop_en,
    output logic [3:0]         fourth,
    output logic [3:0]         third,
    output logic [3:0]         second,
    output logic [3:0]         first,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;       // write pointer
    localparam int LW = $clog2(MSG_LEN + 1);                       // message length
    localparam int PW = $clog2(MSG_LEN + 3);                       // holds MSG_LEN+2
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;     // prescaler

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    state_t         state_q, state_nx;
    logic [IW-1:0]  wr_ptr_q, wr_ptr_nx;
    logic [LW-1:0]  len_q, len_nx;
    logic [PW-1:0]  pos_q, pos_nx;
    logic [CW-1:0]  pre_q, pre_nx;
    logic           done_q, done_nx;
    logic           wr_en;
    logic [3:0]     buf_mem [MSG_LEN];
    logic [3:0]     digit_q [4];
    logic [3:0]     digit_nx [4];

    // ---------------------------------------------------------------------
    // Next-state logic. Priority: clear, then pause, then step/start.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx  = state_q;
        wr_ptr_nx = wr_ptr_q;
        len_nx    = len_q;
        pos_nx    = pos_q;
        pre_nx    = pre_q;
        done_nx   = 1'b0;
        wr_en     = 1'b0;

        if (clear) begin
            state_nx  = IDLE;
            wr_ptr_nx = '0;
            len_nx    = '0;
            pos_nx    = '0;
            pre_nx    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld.load_valid) begin
                        wr_en = 1'b1;
                        // Filling the last entry closes the message even without
                        // load_last, so the buffer can never be overrun.
                        if (ld.load_last || (wr_ptr_q == IW'(MSG_LEN - 1))) begin
                            state_nx = READY;
                            len_nx   = LW'(wr_ptr_q) + LW'(1);
                        end else begin
                            wr_ptr_nx = wr_ptr_q + IW'(1);
                        end
                    end
                end
                READY: begin
                    if (start && !pause) begin
                        state_nx = SCROLL;
                        pos_nx   = '0;
                        pre_nx   = '0;
                    end
                end
                SCROLL: begin
                    if (!pause) begin
                        if (pre_q == CW'(TICK_DIV - 1)) begin
                            pre_nx = '0;
                            if (int'(pos_q) < int'(len_q) + 2) begin
                                pos_nx = pos_q + PW'(1);
                            end else if (loop_en) begin
                                pos_nx = '0;
                            end else begin
                                state_nx = READY;
                                pos_nx   = '0;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            pre_nx = pre_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Digit k (0 = fourth .. 3 = first) shows buf[pos-3+k]. The index is
    // formed as pos+k and compared against 3 so that positions left of the
    // message decode as PAD instead of wrapping around the buffer.
    // Digits are computed from the next state so the registered outputs
    // change on the same edge as state/pos.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            digit_nx[k] = PAD;
            if ((state_nx == SCROLL) &&
                (int'(pos_nx) + k >= 3) &&
                (int'(pos_nx) + k - 3 < int'(len_q))) begin
                digit_nx[k] = buf_mem[IW'(int'(pos_nx) + k - 3)];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            pos_q    <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                digit_q[k] <= PAD;
            end
        end else begin
            state_q  <= state_nx;
            wr_ptr_q <= wr_ptr_nx;
            len_q    <= len_nx;
            pos_q    <= pos_nx;
            pre_q    <= pre_nx;
            done_q   <= done_nx;
            for (int k = 0; k < 4; k++) begin
                digit_q[k] <= digit_nx[k];
            end
        end
    end

    // Message storage needs no reset: entries are only read below len_q,
    // and len_q is zero until the entries have been written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q] <= ld.load_code;
        end
    end

    assign ld.load_ready = (state_q == IDLE);
    assign busy          = (state_q == SCROLL);
    assign done          = done_q;
    assign dbg_state     = state_q;
    assign fourth        = digit_q[0];
    assign third         = digit_q[1];
    assign second        = digit_q[2];
    assign first         = digit_q[3];

endmodule

// File: doc/display_scroller.md
Name: display_scroller

Overview:
- Sequences the four digit codes (fourth, third, second, first) that feed the four-digit seven-segment multiplexer.
- Holds a short message of 4-bit display codes, loaded through a valid/ready handshake.
- Scrolls the message right-to-left across the four digits at a programmable step rate, either once or continuously.
- Sits between the application logic (score or message source) and the display multiplexer.

Parameters:
MSG_LEN, 8, maximum number of codes held in the message buffer (2..16)
TICK_DIV, 25000000, clock cycles per scroll step (>=2); 4 Hz at 100 MHz
PAD, 4'd15, code driven on digit positions with no message character (decodes to dash)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush: empties buffer, returns to IDLE
load_valid  input  1  load_code is valid this cycle
load_ready  output  1  buffer accepts a code this cycle
load_code  input  4  display code to append
load_last  input  1  qualifies load_code as the final message code
start  input  1  begin scrolling (sampled in READY only)
pause  input  1  freeze step prescaler and position while high
loop_en  input  1  1 = restart after last step, 0 = one-shot
fourth  output  4  leftmost digit code
third  output  4  digit code
second  output  4  digit code
first  output  4  rightmost digit code
busy  output  1  high in SCROLL
done  output  1  one-cycle pulse when a one-shot scroll completes

Behaviour:
- Reset (reset=0): state=IDLE; wr_ptr=0; len=0; pos=0; prescaler=0; all digit outputs=PAD; load_ready=1; busy=0; done=0. Buffer contents are don't-care.
- State IDLE:
  - load_ready=1; digits=PAD.
  - A transfer occurs when load_valid && load_ready: buf[wr_ptr]<=load_code; wr_ptr++.
  - Go to READY, with len = number of codes accepted, when load_last is high on the transfer or the transfer fills entry MSG_LEN-1 (overflow guard).
- State READY:
  - load_ready=0; digits=PAD; buffer retained.
  - start=1 -> SCROLL with pos=0, prescaler=0.
- State SCROLL:
  - busy=1.
  - Digit k (k=0 fourth .. 3 first) shows buf[pos-3+k] when 0 <= pos-3+k < len, else PAD.
  - pos=0 places buf[0] on first only. pos=len+2 places buf[len-1] on fourth only.
  - Prescaler counts 0..TICK_DIV-1. The step fires when it wraps, so the first step comes a full TICK_DIV cycles after start.
  - On a step with pos<len+2: pos++.
  - On a step with pos==len+2 and loop_en=1: pos=0.
  - On a step with pos==len+2 and loop_en=0: go to READY, digits=PAD, done=1 for exactly one cycle.
  - pause=1 holds prescaler and pos; outputs are unchanged.
  - loop_en is sampled only at the final step.
- Latency: digit outputs are registered and reflect a state or pos change on the clock edge that makes it. No combinational path from inputs to outputs except load_ready, which is a decode of state.
- Priority: clear > pause > step/start.
  - clear in any state -> IDLE, wr_ptr=0, len=0, pos=0, digits=PAD, done=0 the next cycle.
  - clear together with load_valid discards the code.
- start in IDLE or SCROLL is ignored. load_valid outside IDLE is ignored (no transfer, load_ready=0).
- Reset asserted mid-scroll or mid-load: immediate return to reset values. No partial message survives.
- Widths:
  - pos width holds MSG_LEN+2.
  - Index pos-3+k is computed signed or with an offset so negative values decode as PAD. No wrap-around indexing.
- Single-code message (len=1): 3 steps, buf[0] walks first -> second -> third -> fourth, then completes.

Test Plan:
- Reset values: reset=0 for 3 cycles -> all four digits = 4'd15, load_ready=1, busy=0, done=0. Release reset -> outputs unchanged.
- Load and one-shot scroll (TICK_DIV=4): load 1,2,3 with last on 3, loop_en=0, pulse start.
  - Every 4 cycles {fourth,third,second,first} steps through FFF1, FF12, F123, 123F, 23FF, 3FFF.
  - Then FFFF with done high for 1 cycle; state READY, busy=0.
- Loop mode: same message with loop_en=1 -> after 3FFF the next step shows FFF1. done never pulses over 3 full passes.
- Overflow guard: MSG_LEN=8, push 10 codes with load_last=0.
  - Exactly 8 are accepted; load_ready drops after the 8th.
  - Scroll shows codes 0..7 only, 10 steps total.
- Pause and priority:
  - pause high for 10 cycles mid-scroll -> digits frozen; after release, the step fires after the remaining prescaler count.
  - clear with start in the same cycle -> IDLE, FFFF, load_ready=1.
- Async reset mid-scroll: drop reset between clock edges during pos=2 -> outputs go to PAD immediately without a clock edge; a new load is accepted after release.
